ndp_tile_feeder: RTL and testbench
==================================

# ndp_tile_feeder

Upstream operand feeder for `NDP_unit`. It accepts one GEMM tile as a stream of (A-column, B-row) beat pairs over a valid/ready handshake and buffers the whole tile. It then resets the systolic array, replays the beats one per cycle onto `in_a`/`in_b`, and raises `in_done_flag`. The next tile is accepted only after the array reports `calc_done_flag`.

## Interface
- WIDTH, 16, element width in bits
- ARR_HEIGHT, 4, PE rows per systolic array
- ARR_WIDTH, 4, PE columns per systolic array
- SYS_HEIGHT, 1, arrays stacked vertically
- SYS_WIDTH, 1, arrays stacked horizontally
- MAX_K, 16, buffer depth; maximum inner dimension per tile (power of two, ≥2)
- Derived constants: A_W = SYS_HEIGHT·ARR_HEIGHT·WIDTH; B_W = SYS_WIDTH·ARR_WIDTH·WIDTH

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  producer beat valid
- s_ready  out  1  feeder can accept a beat
- s_a  in  A_W  one column of A; element r at bits [r·WIDTH +: WIDTH]
- s_b  in  B_W  one row of B; element c at bits [c·WIDTH +: WIDTH]
- s_last  in  1  marks the final beat of a tile
- array_reset  out  1  active-high reset to `NDP_unit`
- out_a  out  A_W  drives `NDP_unit.in_a`
- out_b  out  B_W  drives `NDP_unit.in_b`
- in_done_flag  out  1  drives `NDP_unit.in_done_flag`
- calc_done_flag  in  1  from `NDP_unit`
- busy  out  1  high in every state except LOAD
- tile_done  out  1  one-cycle pulse when a tile completes
- err_overflow  out  1  sticky flag; set on MAX_K beats without s_last

## Operation
- Storage:
  - MAX_K-entry buffer of {s_a, s_b} pairs.
  - Write index `wr` and tile length `k_len`, each $clog2(MAX_K)+1 bits wide.
  - Read index `rd`.
- States: LOAD, CLEAR, STREAM, DONE.
- LOAD:
  - s_ready = 1.
  - A beat is accepted when s_valid & s_ready; it is written to buf[wr] and wr increments.
  - If the accepted beat has s_last = 1, or it is the MAX_K-th beat: k_len = wr+1, go to CLEAR.
  - If the MAX_K-th beat is accepted with s_last = 0, set err_overflow. The tile is closed at MAX_K beats regardless of s_last.
- CLEAR (exactly 1 cycle):
  - array_reset = 1, s_ready = 0, rd = 0.
  - Go to STREAM.
- STREAM:
  - out_a/out_b = buf[rd], registered.
  - rd increments each cycle.
  - After the beat at rd = k_len−1 is presented, go to DONE.
  - array_reset = 0.
- DONE:
  - in_done_flag = 1, held.
  - out_a/out_b hold the last streamed beat.
  - On calc_done_flag = 1: pulse tile_done, clear wr and in_done_flag, go to LOAD.
- calc_done_flag is ignored in LOAD, CLEAR and STREAM.
- err_overflow clears only on reset.
- Reset (reset = 0, any state, asynchronous):
  - State goes to LOAD; wr, rd, k_len = 0.
  - s_ready = 0 while reset is asserted.
  - array_reset = 1, out_a = 0, out_b = 0.
  - in_done_flag = 0, tile_done = 0, err_overflow = 0, busy = 0.
  - Buffer contents are not cleared.
  - After reset releases: s_ready = 1 and array_reset = 0 from the first edge.

## Timing
- All outputs are registered except s_ready, which is combinational from the state.
- Back-to-back load: first beat accepted at edge c, last (K-th) beat at edge c+K−1.
- Cycle c+K: CLEAR (array_reset high).
- Cycles c+K+1 … c+2K: STREAM; beat j appears on out_a/out_b during cycle c+K+1+j.
- Cycle c+2K+1 onward: in_done_flag = 1.
- If calc_done_flag is sampled high at edge t in DONE:
  - tile_done is high during cycle t+1 only.
  - s_ready is high from cycle t+1.
- Producer stalls (s_valid = 0) in LOAD only stretch the load phase. STREAM never stalls.
- K = 1: CLEAR, one STREAM cycle, then DONE.

## Test plan
- Single 4×5 by 5×4 tile (K = 5), fp16 values from the 2-stage vector set:
  - array_reset high exactly 1 cycle.
  - 5 consecutive out_a/out_b beats match s_a/s_b in order.
  - in_done_flag rises the cycle after beat 4.
  - Array out_c equals the vector R.
- Tile with s_valid toggling every other cycle (K = 3), then a 2-cycle calc_done_flag:
  - Stream is still 3 contiguous beats.
  - tile_done is one cycle wide.
  - s_ready returns 1 exactly one cycle after calc_done_flag is sampled.
- 16 beats with s_last = 0 (MAX_K = 16):
  - err_overflow = 1, k_len = 16, s_ready = 0 after the 16th beat.
  - 17th s_valid is not accepted.
- K = 1 tile with A = 16'h3C00 in all rows and B = 16'h4000 in all columns:
  - A single stream beat is followed by in_done_flag.
  - Result is all 16'h4000.
- reset pulled low mid-STREAM (after beat 2 of 5):
  - All outputs are at their reset values immediately, asynchronously.
  - After release: LOAD with s_ready = 1, err_overflow = 0, and a fresh tile completes correctly.
- calc_done_flag forced high during STREAM:
  - Ignored; in_done_flag and tile_done are unaffected until DONE.

Source files
------------

// File: rtl/ndp_tile_feeder.sv
// Buffers one GEMM tile of (A-column, B-row) beats, then replays it onto the NDP_unit operand inputs.
// Latency: K load beats, 1 array-reset cycle, K stream beats, then in_done_flag until calc_done_flag.
// Backpressure: s_ready is high only in LOAD; the stream phase never stalls.
module ndp_tile_feeder #(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int SYS_HEIGHT = 1,
    parameter int SYS_WIDTH  = 1,
    parameter int MAX_K      = 16,
    localparam int A_W = SYS_HEIGHT * ARR_HEIGHT * WIDTH,
    localparam int B_W = SYS_WIDTH * ARR_WIDTH * WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [A_W-1:0] s_a,
    input  logic [B_W-1:0] s_b,
    input  logic           s_last,
    output logic           array_reset,
    output logic [A_W-1:0] out_a,
    output logic [B_W-1:0] out_b,
    output logic           in_done_flag,
    input  logic           calc_done_flag,
    output logic           busy,
    output logic           tile_done,
    output logic           err_overflow
);

    localparam int IW = $clog2(MAX_K);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] wr;
    logic [CW-1:0] rd;
    logic [CW-1:0] k_len;

    // No reset on the tile storage: contents are always rewritten before they are read.
    logic [A_W+B_W-1:0] tile_mem [MAX_K];

    logic accept;
    logic last_slot;
    logic close_tile;
    logic stream_end;
    logic stream_rd;

    // Ready only while loading; forced low while reset is held.
    assign s_ready    = reset && (state == LOAD);
    assign accept     = s_valid && s_ready;
    assign last_slot  = (wr == CW'(MAX_K - 1));
    assign close_tile = accept && (s_last || last_slot);
    assign stream_end = (rd == k_len);
    // CLEAR fetches beat 0 so it is on the outputs in the first STREAM cycle.
    assign stream_rd  = (state == CLEAR) || ((state == STREAM) && !stream_end);

    // Next-state selection for the load / clear / stream / done sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (close_tile) state_nxt = CLEAR;
            CLEAR:   state_nxt = STREAM;
            STREAM:  if (stream_end) state_nxt = DONE;
            DONE:    if (calc_done_flag) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // State, indices, registered control outputs and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= LOAD;
            wr           <= '0;
            rd           <= '0;
            k_len        <= '0;
            array_reset  <= 1'b1;
            in_done_flag <= 1'b0;
            busy         <= 1'b0;
            tile_done    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_nxt;
            array_reset  <= (state_nxt == CLEAR);
            in_done_flag <= (state_nxt == DONE);
            busy         <= (state_nxt != LOAD);
            tile_done    <= (state == DONE) && calc_done_flag;
            if (accept) begin
                wr <= wr + 1'b1;
            end
            if (close_tile) begin
                k_len <= wr + 1'b1;
                rd    <= '0;
            end
            if (accept && last_slot && !s_last) begin
                err_overflow <= 1'b1;
            end
            if (stream_rd) begin
                rd <= rd + 1'b1;
            end
            if ((state == DONE) && calc_done_flag) begin
                wr <= '0;
            end
        end
    end

    // Operand output registers; they hold the last beat once streaming ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_a <= '0;
            out_b <= '0;
        end else if (stream_rd) begin
            {out_a, out_b} <= tile_mem[rd[IW-1:0]];
        end
    end

    // Beat capture into the tile buffer.
    always_ff @(posedge clk) begin
        if (accept) begin
            tile_mem[wr[IW-1:0]] <= {s_a, s_b};
        end
    end

endmodule

// File: tb/tb_ndp_tile_feeder.sv
module tb_ndp_tile_feeder;

    localparam int A_W = 64;
    localparam int B_W = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           calc_done_flag = 1'b0;
    logic [A_W-1:0] s_a = '0;
    logic [B_W-1:0] s_b = '0;
    logic           s_ready;
    logic           array_reset;
    logic           in_done_flag;
    logic           busy;
    logic           tile_done;
    logic           err_overflow;
    logic [A_W-1:0] out_a;
    logic [B_W-1:0] out_b;

    int n_chk = 0;
    int n_err = 0;

    logic [A_W-1:0] va [16];
    logic [B_W-1:0] vb [16];

    ndp_tile_feeder #(
        .WIDTH(16), .ARR_HEIGHT(4), .ARR_WIDTH(4),
        .SYS_HEIGHT(1), .SYS_WIDTH(1), .MAX_K(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_a(s_a),
        .s_b(s_b),
        .s_last(s_last),
        .array_reset(array_reset),
        .out_a(out_a),
        .out_b(out_b),
        .in_done_flag(in_done_flag),
        .calc_done_flag(calc_done_flag),
        .busy(busy),
        .tile_done(tile_done),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Distinct fp16-style element patterns per beat and per lane.
    task automatic fill(input logic [15:0] base);
        logic [15:0] e;
        for (int j = 0; j < 16; j++) begin
            e = base + 16'(j * 4);
            va[j] = {e + 16'd3, e + 16'd2, e + 16'd1, e};
            vb[j] = {e ^ 16'h8300, e ^ 16'h8200, e ^ 16'h8100, e ^ 16'h8000};
        end
    endtask

    // Called at a negedge in LOAD; returns at the negedge of the CLEAR cycle.
    task automatic load_tile(input int k, input bit gap, input bit mark_last);
        for (int j = 0; j < k; j++) begin
            if (gap && j > 0) begin
                s_valid = 1'b0;
                @(negedge clk);
                chk("gap_rdy", 64'(s_ready), 64'd1);
            end
            chk("load_rdy", 64'(s_ready), 64'd1);
            s_valid = 1'b1;
            s_a     = va[j];
            s_b     = vb[j];
            s_last  = mark_last && (j == k - 1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called at the CLEAR negedge; returns at the first DONE negedge.
    task automatic check_stream(input int k, input bit cd_during);
        chk("clr_arst", 64'(array_reset), 64'd1);
        chk("clr_rdy", 64'(s_ready), 64'd0);
        chk("clr_busy", 64'(busy), 64'd1);
        chk("clr_done", 64'(in_done_flag), 64'd0);
        calc_done_flag = cd_during;
        for (int j = 0; j < k; j++) begin
            @(negedge clk);
            chk("strm_arst", 64'(array_reset), 64'd0);
            chk("strm_a", out_a, va[j]);
            chk("strm_b", out_b, vb[j]);
            chk("strm_done", 64'(in_done_flag), 64'd0);
            chk("strm_td", 64'(tile_done), 64'd0);
            chk("strm_rdy", 64'(s_ready), 64'd0);
        end
        @(negedge clk);
        calc_done_flag = 1'b0;
        chk("done_flag", 64'(in_done_flag), 64'd1);
        chk("done_hold_a", out_a, va[k-1]);
        chk("done_hold_b", out_b, vb[k-1]);
        chk("done_td", 64'(tile_done), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
    endtask

    // Called at a DONE negedge; holds calc_done_flag for 'hold' cycles.
    task automatic finish_tile(input int hold);
        calc_done_flag = 1'b1;
        @(negedge clk);
        chk("td_pulse", 64'(tile_done), 64'd1);
        chk("td_rdy", 64'(s_ready), 64'd1);
        chk("td_done_clr", 64'(in_done_flag), 64'd0);
        chk("td_busy", 64'(busy), 64'd0);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk("td_width", 64'(tile_done), 64'd0);
        end
        calc_done_flag = 1'b0;
        @(negedge clk);
        chk("td_after", 64'(tile_done), 64'd0);
        chk("td_after_rdy", 64'(s_ready), 64'd1);
    endtask

    initial begin
        // Reset values
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 64'(s_ready), 64'd0);
        chk("rst_arst", 64'(array_reset), 64'd1);
        chk("rst_a", out_a, 64'd0);
        chk("rst_b", out_b, 64'd0);
        chk("rst_done", 64'(in_done_flag), 64'd0);
        chk("rst_td", 64'(tile_done), 64'd0);
        chk("rst_ovf", 64'(err_overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 64'(s_ready), 64'd1);
        chk("rel_arst", 64'(array_reset), 64'd0);
        chk("rel_busy", 64'(busy), 64'd0);

        // K = 5 back-to-back tile, in_done_flag held in DONE
        fill(16'h3C00);
        load_tile(5, 1'b0, 1'b1);
        check_stream(5, 1'b0);
        chk("t1_ovf", 64'(err_overflow), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t1_hold_done", 64'(in_done_flag), 64'd1);
            chk("t1_hold_a", out_a, va[4]);
            chk("t1_hold_rdy", 64'(s_ready), 64'd0);
        end
        finish_tile(1);

        // K = 3 with producer gaps, calc_done_flag high during CLEAR/STREAM, 2-cycle calc_done
        fill(16'h4400);
        load_tile(3, 1'b1, 1'b1);
        check_stream(3, 1'b1);
        finish_tile(2);

        // K = 1 tile
        va[0] = {4{16'h3C00}};
        vb[0] = {4{16'h4000}};
        load_tile(1, 1'b0, 1'b1);
        check_stream(1, 1'b0);
        finish_tile(1);

        // 16 beats without s_last: closes at MAX_K, flags overflow, refuses further beats
        fill(16'h5000);
        load_tile(16, 1'b0, 1'b0);
        chk("ovf_flag", 64'(err_overflow), 64'd1);
        s_valid = 1'b1;
        s_a = '1;
        s_b = '1;
        chk("ovf_rdy", 64'(s_ready), 64'd0);
        check_stream(16, 1'b0);
        s_valid = 1'b0;
        finish_tile(1);
        chk("ovf_sticky", 64'(err_overflow), 64'd1);

        // Asynchronous reset mid-stream, then a fresh tile
        fill(16'h6000);
        load_tile(5, 1'b0, 1'b1);
        chk("rs_clr_arst", 64'(array_reset), 64'd1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("rs_beat", out_a, va[j]);
        end
        #2 reset = 1'b0;
        #1;
        chk("rs_a", out_a, 64'd0);
        chk("rs_b", out_b, 64'd0);
        chk("rs_arst", 64'(array_reset), 64'd1);
        chk("rs_rdy", 64'(s_ready), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_done", 64'(in_done_flag), 64'd0);
        chk("rs_td", 64'(tile_done), 64'd0);
        chk("rs_ovf", 64'(err_overflow), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_rel_rdy", 64'(s_ready), 64'd1);
        chk("rs_rel_arst", 64'(array_reset), 64'd0);
        chk("rs_rel_ovf", 64'(err_overflow), 64'd0);
        fill(16'h7000);
        load_tile(2, 1'b0, 1'b1);
        check_stream(2, 1'b0);
        finish_tile(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
